// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Depth default is shared with the instruction memory itself.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_PAYLOAD,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_LEN   = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_CSUM  = 2'b11;

  localparam int IMEM_BYTES = 36;

endpackage

// File: rtl/imem_loader.sv
// Streams a framed program image (LEN_LO, LEN_HI, payload, XOR CHK)
// into instruction memory from byte 0 and holds the CPU until it commits.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-low reset
//   start            begins a load from IDLE, DONE or ERR
//   s_valid/s_data   input byte stream, s_ready accepts it
//   mem_we/addr/wdata  byte write port, one cycle after the handshake
//   busy/done/error/err_code  load status
//   cpu_hold         1 keeps the CPU in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = IMEM_BYTES,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic              cpu_hold
);

  localparam int          CW      = ADDR_W + 1;
  localparam logic [15:0] MAX_LEN = 16'(MEM_BYTES);

  state_t            state_q;
  state_t            state_d;
  logic [15:0]       len_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_inc;
  logic [7:0]        csum_q;
  logic [1:0]        code_q;
  logic [1:0]        code_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              loading;
  logic              idle_like;
  logic              xfer;
  logic              go;
  logic [15:0]       len_full;

  assign loading = state_q inside {S_LEN_LO, S_LEN_HI,
                                   S_PAYLOAD, S_CHECK};
  assign idle_like = state_q inside {S_IDLE, S_DONE, S_ERR};

  assign s_ready  = loading;
  assign xfer     = s_valid & loading;
  assign go       = start & idle_like;
  assign len_full = {s_data, len_q[7:0]};
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          code_d  = ERR_NONE;
        end
      end
      S_LEN_LO: begin
        if (xfer) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) begin
          if (len_full > MAX_LEN) begin
            state_d = S_ERR;
            code_d  = ERR_LEN;
          end else if (len_full[1:0] != 2'b00) begin
            state_d = S_ERR;
            code_d  = ERR_ALIGN;
          end else if (len_full == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (xfer && 16'(cnt_inc) == len_q)
          state_d = S_CHECK;
      end
      S_CHECK: begin
        if (xfer) begin
          if (s_data == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            code_d  = ERR_CSUM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset wins over a same-edge payload handshake, so a write that
  // would land on the next cycle never appears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      code_q  <= ERR_NONE;
      len_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      we_q    <= 1'b0;
      if (go) begin
        len_q  <= '0;
        cnt_q  <= '0;
        csum_q <= '0;
      end
      if (xfer && state_q == S_LEN_LO)
        len_q[7:0] <= s_data;
      if (xfer && state_q == S_LEN_HI)
        len_q[15:8] <= s_data;
      if (xfer && state_q == S_PAYLOAD) begin
        we_q    <= 1'b1;
        addr_q  <= cnt_q[ADDR_W-1:0];
        wdata_q <= s_data;
        csum_q  <= csum_q ^ s_data;
        cnt_q   <= cnt_inc;
      end
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = loading;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);
  assign err_code  = code_q;
  assign cpu_hold  = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as
// payload bytes are driven and popped as mem_we pulses appear.
module tb_imem_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic          cpu_hold;

  int vecs = 0;
  int errs = 0;

  logic [AW+7:0] exp_q[$];
  logic [AW+7:0] e;

  logic [7:0] pay [8] = '{8'h20, 8'h10, 8'h01, 8'h00,
                          8'h22, 8'h30, 8'h85, 8'h00};

  imem_loader #(.MEM_BYTES(36), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_write addr=%0d data=%02h",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          errs++;
          $display("FAIL write got=%0d/%02h exp=%0d/%02h",
                   mem_addr, mem_wdata, e[AW+7:8], e[7:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    s_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      vecs++;
      errs++;
      $display("FAIL send_timeout byte=%02h s_ready=%b exp=1",
               b, s_ready);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    vecs++;
    if ({busy, cpu_hold, done, error} !== 4'b1100) begin
      errs++;
      $display("FAIL start_status got=%b exp=1100",
               {busy, cpu_hold, done, error});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0;
    s_valid = 1'b0; s_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({s_ready, mem_we, mem_addr, mem_wdata, busy, done,
         error, err_code, cpu_hold} !== {2'b00, 6'd0, 8'h00,
         3'b000, 2'b00, 1'b1}) begin
      errs++;
      $display("FAIL reset_state rdy=%b we=%b a=%0d d=%02h b=%b dn=%b e=%b c=%b h=%b",
               s_ready, mem_we, mem_addr, mem_wdata, busy,
               done, error, err_code, cpu_hold);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_load(input bit gaps);
    logic [7:0] chk;
    chk = 8'h00;
    pulse_start();
    send(8'h08, gaps ? $urandom_range(0, 3) : 0);
    send(8'h00, gaps ? $urandom_range(0, 3) : 0);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({6'(k), pay[k]});
      chk = chk ^ pay[k];
      // a start during the load must be ignored
      if (gaps && k == 4) start = 1'b1;
      send(pay[k], gaps ? $urandom_range(0, 3) : 0);
      start = 1'b0;
    end
    send(chk, gaps ? $urandom_range(0, 3) : 0);
    vecs++;
    if ({done, error, err_code, cpu_hold, busy} !== 6'b100000) begin
      errs++;
      $display("FAIL good_status got=%b exp=100000",
               {done, error, err_code, cpu_hold, busy});
    end
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL good_writes_left got=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
    vecs++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 6'd7, 8'h00}) begin
      errs++;
      $display("FAIL hold_last got=%b/%0d/%02h exp=0/7/00",
               mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_zero_len();
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({done, error, err_code, cpu_hold} !== 5'b10000) begin
      errs++;
      $display("FAIL zero_len got=%b exp=10000",
               {done, error, err_code, cpu_hold});
    end
  endtask

  task automatic test_len_err(input logic [7:0] lo,
                              input logic [1:0] code);
    pulse_start();
    send(lo, 0);
    send(8'h00, 0);
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({error, done, err_code, cpu_hold, busy, s_ready} !==
        {2'b10, code, 3'b100}) begin
      errs++;
      $display("FAIL len_err_%02h got=%b exp=%b", lo,
               {error, done, err_code, cpu_hold, busy, s_ready},
               {2'b10, code, 3'b100});
    end
  endtask

  task automatic test_bad_csum();
    pulse_start();
    send(8'h08, 0);
    send(8'h00, 0);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({6'(k), pay[k]});
      send(pay[k], 0);
    end
    send(8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({error, done, err_code, cpu_hold} !== 5'b10111) begin
      errs++;
      $display("FAIL bad_csum got=%b exp=10111",
               {error, done, err_code, cpu_hold});
    end
    vecs++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL csum_writes_left got=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_midload();
    pulse_start();
    send(8'h08, 0);
    send(8'h00, 0);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({6'(k), pay[k]});
      send(pay[k], 0);
    end
    // 4th byte offered on the same edge as reset: no write may follow
    s_valid = 1'b1;
    s_data  = pay[3];
    reset   = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b1;
    s_valid = 1'b0;
    vecs++;
    if ({s_ready, mem_we, mem_addr, mem_wdata, busy, done,
         error, err_code, cpu_hold} !== {2'b00, 6'd0, 8'h00,
         3'b000, 2'b00, 1'b1}) begin
      errs++;
      $display("FAIL midload_reset we=%b a=%0d d=%02h b=%b dn=%b e=%b c=%b h=%b",
               mem_we, mem_addr, mem_wdata, busy, done,
               error, err_code, cpu_hold);
    end
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL midload_writes_left got=%0d exp=0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_good_load(1'b0);
    test_zero_len();
    test_len_err(8'h28, 2'b01);
    test_len_err(8'h06, 2'b10);
    test_bad_csum();
    test_good_load(1'b1);
    test_reset_midload();
    test_good_load(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
